// File: rtl/gate_tester_pkg.sv
// Shared definitions for the two-input gate tester: FSM encoding,
// reference truth tables and a one-hot helper for combination indices.
package gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Bit k of each table is the expected Y for {A,B} == k.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  function automatic logic [3:0] combo_bit(input logic [1:0] idx);
    combo_bit = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/gate_tester.sv
// Exhaustive two-input gate tester: steps {A,B} through 00..11, holds each
// combination SETTLE_CYCLES cycles and compares Y against a captured truth table.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] tt,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] tt_reg;
  logic       sample;
  logic       mismatch;
  logic [3:0] mask_next;

  // Y is only looked at on the last cycle of each combination.
  assign sample    = (state == ST_SETTLE) && (cnt == CNT_LAST);
  assign mismatch  = (y != tt_reg[idx]);
  assign mask_next = mismatch ? (fail_mask | combo_bit(idx)) : fail_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      cnt       <= 4'd0;
      tt_reg    <= 4'd0;
      fail_mask <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tt_reg    <= tt;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            idx       <= 2'd0;
            cnt       <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (sample) begin
            cnt       <= 4'd0;
            fail_mask <= mask_next;
            if (idx == 2'd3) pass <= (mask_next == 4'd0);
            else             idx  <= idx + 2'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (sample && (idx == 2'd3)) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    a    = 1'b0;
    b    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SETTLE: begin
        a    = idx[1];
        b    = idx[0];
        busy = 1'b1;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets clock cycles each input combination is held before Y is sampled; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all flops update on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request one test run; sampled only in IDLE.
REQ-005 TT  input  4  expected truth table; TT[{A,B}] is the expected Y for that combination (AND = 4'b1000).
REQ-006 A  output  1  drive to gate-under-test input A.
REQ-007 B  output  1  drive to gate-under-test input B.
REQ-008 Y  input  1  output of gate under test.
REQ-009 BUSY  output  1  high while a run is in progress (states SETTLE).
REQ-010 DONE  output  1  one-cycle pulse marking run completion.
REQ-011 PASS  output  1  1 when the last completed run had no mismatches.
REQ-012 FAIL_MASK  output  4  bit k set when combination k ({A,B}=k) mismatched in the last completed run.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, FINISH.
REQ-014 In IDLE with START=1 at an edge: capture TT into TT_reg, clear FAIL_MASK, clear PASS, set idx=0, cnt=0, go to SETTLE.
REQ-015 A SHALL equal idx[1] and B SHALL equal idx[0] while in SETTLE; A=B=0 in IDLE and FINISH.
REQ-016 In SETTLE, cnt increments each cycle; at the edge where cnt==SETTLE_CYCLES-1, Y is sampled and compared with TT_reg[idx].
REQ-017 On that sampling edge: a mismatch sets FAIL_MASK[idx]; cnt returns to 0; if idx<3, idx increments and state stays SETTLE; if idx==3, state goes to FINISH.
REQ-018 Combinations SHALL be applied in order 00, 01, 10, 11, each for exactly SETTLE_CYCLES cycles.
REQ-019 FINISH SHALL last one cycle with DONE=1, PASS=(FAIL_MASK==0), and SHALL return to IDLE at the next edge.
REQ-020 DONE SHALL rise exactly 4*SETTLE_CYCLES edges after the edge that sampled START.
REQ-021 BUSY SHALL be 1 only in SETTLE; DONE SHALL be 1 only in FINISH.
REQ-022 START in SETTLE or FINISH SHALL be ignored and not queued.
REQ-023 TT changes after capture SHALL not affect the run in progress.
REQ-024 PASS and FAIL_MASK SHALL hold their values in IDLE until the next accepted START.
REQ-025 Y SHALL be used only at sampling edges; its value at other times SHALL have no effect.

Reset
REQ-026 RST_N low SHALL immediately force state=IDLE, idx=0, cnt=0, TT_reg=0, A=0, B=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0.
REQ-027 Reset during a run SHALL abort it with no DONE pulse; the first START after RST_N deasserts SHALL start a fresh run.

Structure
REQ-028 A shared package SHALL hold the state encoding and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
REQ-029 The block SHALL be a single module with no sub-modules; the gate under test is instantiated outside it, in the bench or top level.

Verification
REQ-030 SETTLE_CYCLES=2, TT=TT_AND, 2-input AND model on A/B/Y, START pulse -> DONE 8 edges later, PASS=1, FAIL_MASK=4'b0000.
REQ-031 TT=TT_AND with Y tied to 0 -> PASS=0, FAIL_MASK=4'b1000.
REQ-032 TT=TT_AND with an OR model as the gate under test -> PASS=0, FAIL_MASK=4'b0110.
REQ-033 START pulsed again 3 cycles into a run, and TT changed mid-run -> exactly one DONE, result matches the originally captured TT.
REQ-034 RST_N asserted mid-run (idx=2) -> all outputs 0 immediately, no DONE; the next START completes a normal run.
REQ-035 SETTLE_CYCLES=1 and =3 -> DONE at 4 and 12 edges after START; A/B sequence 00, 01, 10, 11, each held for SETTLE_CYCLES cycles.
